// File: rtl/sync_fifo_status.sv
// sync_fifo_status: single-clock FIFO with show-ahead read data, occupancy
// and threshold flags, and sticky overflow/underflow error flags.
// DEPTH need not be a power of two; pointers wrap by explicit compare.
module sync_fifo_status #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_fifo_w_stb,
  input  logic [WIDTH-1:0]           i_fifo_w_data,
  input  logic                       i_fifo_r_stb,
  input  logic                       i_fifo_clr_err,
  output logic [WIDTH-1:0]           o_fifo_r_data,
  output logic                       o_fifo_full,
  output logic                       o_fifo_not_full,
  output logic                       o_fifo_empty,
  output logic                       o_fifo_not_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_fifo_count,
  output logic                       o_fifo_almost_full,
  output logic                       o_fifo_almost_empty,
  output logic                       o_fifo_overflow,
  output logic                       o_fifo_underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C       = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C       = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_PTR_C = PW'(DEPTH - 1);

  // Reject illegal parameter combinations at elaboration time.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_status: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_status: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_status: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1 || AE_THRESH >= AF_THRESH) begin : g_bad_ae
    $error("sync_fifo_status: AE_THRESH must be in 0..DEPTH-1 and below AF_THRESH");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;

  // A read needs data; a write needs room, or a slot freed by a same-cycle read.
  assign rd_acc = i_fifo_r_stb && (count_q != '0);
  assign wr_acc = i_fifo_w_stb && ((count_q != DEPTH_C) || rd_acc);

  // Next-state for pointers, occupancy count and sticky error flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch; blocking '=' is correct in always_comb.
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR_C) ? '0 : rd_ptr_q + PW'(1);
    end
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR_C) ? '0 : wr_ptr_q + PW'(1);
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end

    // Clear first so that a same-cycle error event takes priority.
    if (i_fifo_clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (i_fifo_w_stb && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (i_fifo_r_stb && (count_q == '0)) begin
      underflow_d = 1'b1;
    end
  end

  // Control state register with synchronous reset that overrides all strobes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array: written on accepted writes only, never during reset.
  always_ff @(posedge clk) begin
    // NOTE: the memory is deliberately not reset; its contents are only
    // observable after a write, and a reset port would bloat the array.
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= i_fifo_w_data;
    end
  end

  // Show-ahead head data and status flags, all derived from registered state.
  assign o_fifo_r_data       = mem_q[rd_ptr_q];
  assign o_fifo_count        = count_q;
  assign o_fifo_full         = (count_q == DEPTH_C);
  assign o_fifo_not_full     = ~o_fifo_full;
  assign o_fifo_empty        = (count_q == '0);
  assign o_fifo_not_empty    = ~o_fifo_empty;
  assign o_fifo_almost_full  = (count_q >= AF_C);
  assign o_fifo_almost_empty = (count_q <= AE_C);
  assign o_fifo_overflow     = overflow_q;
  assign o_fifo_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_status.sv
// Directed testbench for sync_fifo_status (WIDTH=8, DEPTH=5, AF=4, AE=1).
module tb_sync_fifo_status;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             w_stb = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic             r_stb = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] r_data;
  logic             full, not_full, empty, not_empty;
  logic [CW-1:0]    count;
  logic             almost_full, almost_empty;
  logic             overflow, underflow;

  int tests = 0;
  int fails = 0;

  sync_fifo_status #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_fifo_w_stb        (w_stb),
    .i_fifo_w_data       (w_data),
    .i_fifo_r_stb        (r_stb),
    .i_fifo_clr_err      (clr_err),
    .o_fifo_r_data       (r_data),
    .o_fifo_full         (full),
    .o_fifo_not_full     (not_full),
    .o_fifo_empty        (empty),
    .o_fifo_not_empty    (not_empty),
    .o_fifo_count        (count),
    .o_fifo_almost_full  (almost_full),
    .o_fifo_almost_empty (almost_empty),
    .o_fifo_overflow     (overflow),
    .o_fifo_underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Occupancy and threshold flags expected for a given count.
  task automatic check_state(input string tag, input int exp_cnt);
    check({tag, ".count"},        32'(count),        32'(exp_cnt));
    check({tag, ".full"},         32'(full),         32'(exp_cnt == DEPTH));
    check({tag, ".not_full"},     32'(not_full),     32'(exp_cnt != DEPTH));
    check({tag, ".empty"},        32'(empty),        32'(exp_cnt == 0));
    check({tag, ".not_empty"},    32'(not_empty),    32'(exp_cnt != 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(exp_cnt >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(exp_cnt <= AE));
  endtask

  task automatic check_err(input string tag, input logic exp_ovf, input logic exp_unf);
    check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
    w_stb   = w;
    w_data  = d;
    r_stb   = r;
    clr_err = c;
    @(posedge clk);
    #1;
    w_stb   = 1'b0;
    r_stb   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_q [5];

    // Reset
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    check_state("reset", 0);
    check_err("reset", 1'b0, 1'b0);

    // Fill with 0x11..0x55
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, WIDTH'(i * 8'h11), 1'b0, 1'b0);
      check_state($sformatf("fill%0d", i), i);
      check($sformatf("fill%0d.r_data", i), 32'(r_data), 32'h11);
    end

    // Sixth write while full is rejected
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    check_state("ovf", 5);
    check_err("ovf", 1'b1, 1'b0);
    check("ovf.r_data", 32'(r_data), 32'h11);

    // Clear and rejected write in the same cycle: set wins
    cyc(1'b1, 8'h67, 1'b0, 1'b1);
    check_err("clr_vs_ovf", 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check_err("clr_alone", 1'b0, 1'b0);
    check_state("clr_alone", 5);

    // Drain: 0x11..0x55 in order, rejected data never stored
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("drain%0d.r_data", i), 32'(r_data), 32'(i * 8'h11));
      cyc(1'b0, '0, 1'b1, 1'b0);
      check_state($sformatf("drain%0d", i), 5 - i);
    end
    check_err("drained", 1'b0, 1'b0);

    // Read while empty
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_state("unf", 0);
    check_err("unf", 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check_err("unf_clr", 1'b0, 1'b0);

    // Refill, then simultaneous write 0x77 and read while full
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, WIDTH'(i * 8'h11), 1'b0, 1'b0);
    end
    check_state("refill", 5);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check_state("full_rw", 5);
    check_err("full_rw", 1'b0, 1'b0);
    check("full_rw.r_data", 32'(r_data), 32'h22);

    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44;
    exp_q[3] = 8'h55; exp_q[4] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap%0d.r_data", i), 32'(r_data), 32'(exp_q[i]));
      cyc(1'b0, '0, 1'b1, 1'b0);
      check_state($sformatf("wrap%0d", i), 4 - i);
    end
    check_err("wrapped", 1'b0, 1'b0);

    // Empty with simultaneous write 0xA5 and read: write only
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    check_state("empty_rw", 1);
    check_err("empty_rw", 1'b0, 1'b1);
    check("empty_rw.r_data", 32'(r_data), 32'hA5);

    // Bring count to 3, then reset with both strobes and clr low
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    check_state("pre_rst", 3);
    rst = 1'b1;
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    rst = 1'b0;
    check_state("rst_strobes", 0);
    check_err("rst_strobes", 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check_state("post_rst_idle", 0);

    // FIFO still works after reset
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    check_state("post_rst_wr", 1);
    check("post_rst_wr.r_data", 32'(r_data), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
